alu_sequencer: RTL
==================

# alu_sequencer

Program sequencer for the byte ALU. It holds a small instruction memory and runs it by driving the ALU's `opcode`/`data_in` each cycle. It reads ALU status through opcode `F` to resolve conditional branches, and returns the final accumulator value. It sits between the chip-level I/O and the ALU, so a whole program runs from one `start` pulse instead of one opcode per cycle.

## Interface
- `DEPTH`, default 16: instruction words. The PC is 4 bits; only 16 is supported.
- `STEP_LIMIT`, default 255, range 1–255: watchdog limit on executed instructions.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `prog_we` in 1: write `prog_data` into memory at `prog_addr`. Honoured only in IDLE.
- `prog_addr` in 4: instruction write address.
- `prog_data` in 12: instruction word, `{op[3:0], imm[7:0]}`.
- `start` in 1: begin execution at PC 0. Honoured only in IDLE.
- `busy` out 1: program running.
- `done` out 1: one-cycle pulse on completion (halt or abort).
- `error` out 1: set on watchdog abort; held until next `start` or reset.
- `result` out 8: accumulator captured at halt or abort; held.
- `pc` out 4: current program counter.
- `alu_opcode` out 4: to ALU `opcode`.
- `alu_data` out 8: to ALU `data_in`.
- `alu_result` in 8: from ALU `data_out`.

## Operation
- **States:** IDLE, EXEC, STAT, DONE.
- **Instruction memory:** 16×12 register array, read combinationally at `pc`. Reset does not clear it.
- **IDLE**
  - `alu_opcode`=0, `alu_data`=0.
  - On `start`: `pc`←0, step counter←0, `error`←0, `busy`←1, go to EXEC.
  - If `start` and `prog_we` arrive in the same cycle, the write completes and `start` is also taken.
- **EXEC** decodes `op` = `mem[pc][11:8]`:
  - `0`–`B`: drive `alu_opcode`=`op`, `alu_data`=`imm`; `pc`←`pc`+1 (wraps 15→0); steps+1.
  - `C` (JZ) / `D` (JC): drive `alu_opcode`=`F`, `alu_data`=0; go to STAT.
  - `E` (JMP): drive `alu_opcode`=0; `pc`←`imm[3:0]`; steps+1.
  - `F` (HALT): drive `alu_opcode`=0; `result`←`alu_result`; go to DONE.
- **STAT**
  - Drive `alu_opcode`=0.
  - Test `alu_result[0]` (zero) for JZ, or `alu_result[2]` (carry/borrow) for JC.
  - Taken: `pc`←`imm[3:0]`. Not taken: `pc`←`pc`+1.
  - Steps+1; return to EXEC.
  - The ALU accumulator is unaffected. The next EXEC cycle sees the accumulator on `alu_result`, so a HALT directly after a branch captures the correct value.
- **DONE:** `done`=1, `busy`=0, go to IDLE.
- **Watchdog:** on entry to EXEC with steps == `STEP_LIMIT` and `op` ≠ `F`:
  - do not execute; drive `alu_opcode`=0;
  - `result`←`alu_result`, `error`←1;
  - go to DONE.
- **Ignored inputs:** `start` or `prog_we` while `busy` has no effect.
- **Reset (any state, including mid-run):**
  - `busy`, `done`, `error`, `pc`, `result`, step counter, `alu_opcode`, `alu_data` all = 0; state = IDLE.
  - The ALU shares `rst_n`, so both restart clean.

## Timing
- **Start:** `start` is sampled in cycle 0; the first EXEC is cycle 1.
- **ALU ops, JMP:** 1 cycle each.
- **JZ/JC:** 2 cycles. STAT is the cycle in which the ALU presents status.
- **HALT:**
  - in cycle h: captures the accumulator written by the instruction in cycle h−1;
  - cycle h+1: `done`=1, `busy`=0;
  - cycle h+2: IDLE, `start` accepted.
- **`busy`:** high from cycle 1 through the HALT/abort cycle.
- **`alu_opcode`/`alu_data`:** combinational from state and `mem[pc]`; 0 outside EXEC.
- **`result`, `error`:** valid in the `done` cycle and held after.

## Configuration
- **`ALU_SEQ_WATCHDOG_EN` defined:** step counter and abort as above.
- **Not defined:**
  - no step counter; `error` tied to 0;
  - a program without HALT runs until reset;
  - `STEP_LIMIT` is ignored.

## Test plan
- **Straight-line program:** program 0:`105`, 1:`203`, 2:`F00`; pulse `start` -> `done` in cycle 4, `result`=0x08, `error`=0. `alu_opcode` sequence over cycles 1..3 is 1, 2, 0.
- **JZ taken:** program 0:`100`, 1:`C03`, 2:`1AA`, 3:`F00` -> `result`=0x00. `alu_opcode`=`F` in the JZ cycle, then 0 in STAT.
- **JC not taken / taken:**
  - 0:`110`, 1:`201`, 2:`D04`, 3:`155`, 4:`F00` -> `result`=0x55.
  - With 0:`1FF` instead -> `result`=0x00 (branch taken, skips PC 3).
- **Watchdog:** 0:`E00` with `STEP_LIMIT`=255 and macro defined -> after 255 JMPs, `done`=1, `error`=1, `busy`=0. Next `start` clears `error`.
- **Ignored inputs and reset:**
  - `prog_we` and `start` while `busy` -> memory unchanged, run unaffected.
  - `rst_n`=0 mid-run -> all outputs 0 the next cycle, IDLE.
  - Program retained: a re-`start` gives the same `result`.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Program sequencer for the byte ALU. Holds a 16 x 12-bit instruction memory,
//   runs it from PC 0 on a start pulse and drives the ALU opcode/data each cycle.
//   Conditional branches read ALU status through opcode F. The final
//   accumulator value is captured into result.
//
//   Instruction word: {op[3:0], imm[7:0]}
//     0-B ALU op with imm, C JZ imm, D JC imm, E JMP imm, F HALT
//
//   Optional feature macro: ALU_SEQ_WATCHDOG_EN
//     defined   : step counter aborts a run after STEP_LIMIT instructions
//     undefined : no step counter, error is tied low, STEP_LIMIT is ignored
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   prog_we/addr/data     instruction memory write (IDLE only)
//   start                 begin execution at PC 0 (IDLE only)
//   busy, done, error     run status; done is a one-cycle pulse
//   result                accumulator captured at halt or abort
//   pc                    current program counter
//   alu_opcode, alu_data  to ALU
//   alu_result            from ALU data_out
module alu_sequencer #(
   parameter int DEPTH      = 16,
   parameter int STEP_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [11:0] prog_data,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  result,
   output logic [3:0]  pc,
   output logic [3:0]  alu_opcode,
   output logic [7:0]  alu_data,
   input  logic [7:0]  alu_result
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_STAT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [11:0] mem_r [DEPTH];
   logic [11:0] instr_s;
   logic [3:0]  op_s;
   logic [7:0]  imm_s;
   logic [3:0]  pc_r;
   logic [3:0]  pc_nxt_s;
   logic [3:0]  pc_inc_s;
   logic        abort_s;
   logic        br_taken_s;
   logic        busy_r;
   logic        done_r;
   logic [7:0]  result_r;
   logic [3:0]  alu_opcode_s;
   logic [7:0]  alu_data_s;

   // Only a 16-word memory and a 1..255 step limit are meaningful; other
   // values elaborate this empty marker block so they are easy to spot.
   if (DEPTH != 16 || STEP_LIMIT < 1 || STEP_LIMIT > 255) begin : g_unsupported_config
   end

   assign instr_s  = mem_r[pc_r];
   assign op_s     = instr_s[11:8];
   assign imm_s    = instr_s[7:0];
   assign pc_inc_s = pc_r + 4'd1;

   // In STAT the ALU presents status: bit 0 is zero, bit 2 is carry/borrow.
   assign br_taken_s = (op_s == 4'hC) ? alu_result[0] : alu_result[2];

`ifdef ALU_SEQ_WATCHDOG_EN
   localparam logic [7:0] STEP_LIMIT_C = 8'(STEP_LIMIT);

   logic [7:0] steps_r;
   logic       error_r;
   logic       step_inc_s;

   // A HALT at the limit still completes normally; anything else aborts.
   assign abort_s    = (state_r == ST_EXEC) && (steps_r == STEP_LIMIT_C) && (op_s != 4'hF);
   // ALU ops and JMP count in EXEC; branches count in their STAT cycle.
   assign step_inc_s = ((state_r == ST_EXEC) && (state_nxt_s == ST_EXEC)) || (state_r == ST_STAT);

   // Executed-instruction counter, cleared on every accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         steps_r <= 8'd0;
      end else if ((state_r == ST_IDLE) && start) begin
         steps_r <= 8'd0;
      end else if (step_inc_s) begin
         steps_r <= steps_r + 8'd1;
      end else begin
         steps_r <= steps_r;
      end
   end

   // Abort flag: set by the watchdog, held until the next start or reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         error_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && start) begin
         error_r <= 1'b0;
      end else if (abort_s) begin
         error_r <= 1'b1;
      end else begin
         error_r <= error_r;
      end
   end

   assign error = error_r;
`else
   assign abort_s = 1'b0;
   assign error   = 1'b0;
`endif

   // Instruction memory write port; not reset so programs survive rst_n.
   always_ff @(posedge clk) begin
      if (prog_we && (state_r == ST_IDLE)) begin
         mem_r[prog_addr] <= prog_data;
      end
   end

   // State register and program counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         pc_r    <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
      end
   end

   // Next-state and next-PC decode.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_EXEC;
               pc_nxt_s    = 4'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (abort_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               case (op_s)
                  4'hC, 4'hD: state_nxt_s = ST_STAT;
                  4'hE:       pc_nxt_s    = imm_s[3:0];
                  4'hF:       state_nxt_s = ST_DONE;
                  default:    pc_nxt_s    = pc_inc_s;
               endcase
            end
         end
         ST_STAT: begin
            state_nxt_s = ST_EXEC;
            pc_nxt_s    = br_taken_s ? imm_s[3:0] : pc_inc_s;
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Registered status outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 8'd0;
      end else begin
         busy_r <= (state_nxt_s == ST_EXEC) || (state_nxt_s == ST_STAT);
         done_r <= (state_nxt_s == ST_DONE);
         if ((state_r == ST_EXEC) && (state_nxt_s == ST_DONE)) begin
            result_r <= alu_result;
         end else begin
            result_r <= result_r;
         end
      end
   end

   // ALU drive: only ALU ops and the branch status request are non-zero.
   always_comb begin
      alu_opcode_s = 4'h0;
      alu_data_s   = 8'h00;
      if ((state_r == ST_EXEC) && !abort_s) begin
         case (op_s)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
               alu_opcode_s = op_s;
               alu_data_s   = imm_s;
            end
            4'hC, 4'hD: begin
               alu_opcode_s = 4'hF;
               alu_data_s   = 8'h00;
            end
            default: begin
               alu_opcode_s = 4'h0;
               alu_data_s   = 8'h00;
            end
         endcase
      end else begin
         alu_opcode_s = 4'h0;
         alu_data_s   = 8'h00;
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign result     = result_r;
   assign pc         = pc_r;
   assign alu_opcode = alu_opcode_s;
   assign alu_data   = alu_data_s;

endmodule
